// File: rtl/bit_entry_conditioner.sv
// Synchronizes and debounces a raw step button and data switch, emitting one
// qualified bit per press plus a history shift register and an entry counter.
module bit_entry_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned HIST_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  btn_n,
   input  logic                  sw_data,
   output logic                  bit_out,
   output logic                  bit_valid,
   output logic [HIST_WIDTH-1:0] history,
   output logic [7:0]            bit_count
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   state_t                 state, state_next;
   logic [CW-1:0]          cnt, cnt_next;
   logic [SYNC_STAGES-1:0] btn_sync, sw_sync;
   logic                   btn_s, sw_s;
   logic                   accept;

   // Button flops idle at 1 so a reset never looks like a press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_sync <= '1;
         sw_sync  <= '0;
      end else begin
         btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_n};
         sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw_data};
      end
   end

   assign btn_s = btn_sync[SYNC_STAGES-1];
   assign sw_s  = sw_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (ena) begin
         unique case (state)
            IDLE: begin
               if (!btn_s) begin
                  state_next = PRESS_WAIT;
                  cnt_next   = '0;
               end
            end
            PRESS_WAIT: begin
               if (btn_s) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_next = HELD;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + CW'(1);
               end
            end
            HELD: begin
               if (btn_s) begin
                  state_next = RELEASE_WAIT;
                  cnt_next   = '0;
               end
            end
            RELEASE_WAIT: begin
               if (!btn_s) begin
                  state_next = HELD;
                  cnt_next   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + CW'(1);
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_comb begin
      accept = ena && (state == PRESS_WAIT) && !btn_s && (cnt == CNT_LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         history   <= '0;
         bit_count <= '0;
      end else begin
         bit_valid <= accept;
         if (accept) begin
            bit_out   <= sw_s;
            history   <= {history[HIST_WIDTH-2:0], sw_s};
            bit_count <= bit_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_bit_entry_conditioner.sv
// Directed and randomized bench for bit_entry_conditioner against a
// run-length reference model of the debounced button.
module tb_bit_entry_conditioner;

   localparam int unsigned D = 4;
   localparam int unsigned S = 2;
   localparam int unsigned H = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         ena;
   logic         btn_n;
   logic         sw_data;
   logic         bit_out;
   logic         bit_valid;
   logic [H-1:0] history;
   logic [7:0]   bit_count;

   int checks = 0;
   int errors = 0;

   bit_entry_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .SYNC_STAGES    (S),
      .HIST_WIDTH     (H)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .btn_n    (btn_n),
      .sw_data  (sw_data),
      .bit_out  (bit_out),
      .bit_valid(bit_valid),
      .history  (history),
      .bit_count(bit_count)
   );

   always #5 clk = ~clk;

   // Reference: a press is accepted once btn_s has read 0 on D+1 consecutive
   // enabled edges while armed; re-arming needs D+1 consecutive enabled 1s.
   logic [S-1:0] m_bsync, m_ssync;
   bit           armed;
   int           run;
   logic         exp_valid, exp_out;
   logic [H-1:0] exp_hist;
   int           exp_count;

   always @(posedge clk or negedge rst) begin
      logic bs, ss, acc;
      if (!rst) begin
         m_bsync   = '1;
         m_ssync   = '0;
         armed     = 1'b1;
         run       = 0;
         exp_valid = 1'b0;
         exp_out   = 1'b0;
         exp_hist  = '0;
         exp_count = 0;
      end else begin
         bs  = m_bsync[S-1];
         ss  = m_ssync[S-1];
         acc = 1'b0;
         if (ena) begin
            if (armed) begin
               run = (bs == 1'b0) ? run + 1 : 0;
               if (run == D + 1) begin
                  acc   = 1'b1;
                  armed = 1'b0;
                  run   = 0;
               end
            end else begin
               run = (bs == 1'b1) ? run + 1 : 0;
               if (run == D + 1) begin
                  armed = 1'b1;
                  run   = 0;
               end
            end
         end
         exp_valid = acc;
         if (acc) begin
            exp_out   = ss;
            exp_hist  = (exp_hist << 1) | H'(ss);
            exp_count = (exp_count + 1) % 256;
         end
         m_bsync = {m_bsync[S-2:0], btn_n};
         m_ssync = {m_ssync[S-2:0], sw_data};
      end
   end

   int   ncyc = 0;
   int   pulses = 0;
   int   last_pulse = 0;
   logic last_bit = 1'b0;

   task automatic check_outputs();
      checks++;
      assert (bit_valid === exp_valid) else begin
         errors++;
         $error("FAIL bit_valid: got %b want %b at cycle %0d", bit_valid, exp_valid, ncyc);
      end
      checks++;
      assert (bit_out === exp_out) else begin
         errors++;
         $error("FAIL bit_out: got %b want %b at cycle %0d", bit_out, exp_out, ncyc);
      end
      checks++;
      assert (history === exp_hist) else begin
         errors++;
         $error("FAIL history: got %h want %h at cycle %0d", history, exp_hist, ncyc);
      end
      checks++;
      assert (bit_count === 8'(exp_count)) else begin
         errors++;
         $error("FAIL bit_count: got %0d want %0d at cycle %0d", bit_count, exp_count, ncyc);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      ncyc++;
      check_outputs();
      if (bit_valid === 1'b1) begin
         pulses++;
         last_pulse = ncyc;
         last_bit   = bit_out;
      end
   endtask

   task automatic press_release(input logic b, input int hold, input int rel);
      sw_data = b;
      btn_n   = 1'b0;
      repeat (hold) cyc();
      btn_n = 1'b1;
      repeat (rel) cyc();
   endtask

   task automatic expect_int(input string tag, input int got, input int want);
      checks++;
      assert (got == want) else begin
         errors++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   initial begin
      int         p0, c0;
      logic [4:0] seq;
      logic [7:0] wr_hist;
      logic       b;

      rst = 1'b0; ena = 1'b1; btn_n = 1'b1; sw_data = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      expect_int("reset_bit_valid", int'(bit_valid), 0);
      expect_int("reset_bit_out", int'(bit_out), 0);
      expect_int("reset_history", int'(history), 0);
      expect_int("reset_bit_count", int'(bit_count), 0);
      rst = 1'b1;

      // First press: pulse after edge S+D+1 = 7
      sw_data = 1'b1;
      btn_n   = 1'b0;
      c0 = ncyc; p0 = pulses;
      repeat (20) cyc();
      expect_int("first_pulses", pulses - p0, 1);
      expect_int("first_latency", last_pulse - c0, S + D + 1);
      expect_int("first_bit", int'(last_bit), 1);
      expect_int("first_history", int'(history), 8'h01);
      expect_int("first_count", int'(bit_count), 1);
      btn_n = 1'b1;
      repeat (10) cyc();

      // Glitch press
      p0 = pulses;
      press_release(1'b1, 3, 10);
      expect_int("glitch_pulses", pulses - p0, 0);
      expect_int("glitch_history", int'(history), 8'h01);
      expect_int("glitch_count", int'(bit_count), 1);

      // Release bounce while held
      p0 = pulses;
      sw_data = 1'b0;
      btn_n   = 1'b0;
      repeat (20) cyc();
      btn_n = 1'b1;
      repeat (2) cyc();
      btn_n = 1'b0;
      repeat (10) cyc();
      expect_int("bounce_pulses", pulses - p0, 1);
      btn_n = 1'b1;
      repeat (10) cyc();
      p0 = pulses;
      press_release(1'b1, 20, 10);
      expect_int("after_bounce_pulses", pulses - p0, 1);
      expect_int("after_bounce_history", int'(history), 8'h05);
      expect_int("after_bounce_count", int'(bit_count), 3);

      // Fresh reset, then enter 0,1,0,0,1
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      seq = 5'b10010;
      p0 = pulses;
      for (int i = 0; i < 5; i++) begin
         press_release(seq[i], 12, 10);
         expect_int("seq_bit", int'(last_bit), int'(seq[i]));
      end
      expect_int("seq_pulses", pulses - p0, 5);
      expect_int("seq_history", int'(history), 8'b0000_1001);
      expect_int("seq_count", int'(bit_count), 5);

      // ena dropped midway through the press debounce
      sw_data = 1'b1;
      btn_n   = 1'b0;
      p0 = pulses;
      repeat (4) cyc();
      ena = 1'b0;
      repeat (10) cyc();
      expect_int("frozen_pulses", pulses - p0, 0);
      ena = 1'b1;
      c0 = ncyc;
      repeat (8) cyc();
      expect_int("resume_pulses", pulses - p0, 1);
      expect_int("resume_latency", last_pulse - c0, 3);
      expect_int("resume_count", int'(bit_count), 6);
      btn_n = 1'b1;
      repeat (10) cyc();

      // 250 more entries wraps the count to 0
      wr_hist = '0;
      p0 = pulses;
      for (int i = 0; i < 250; i++) begin
         b = 1'($urandom_range(0, 1));
         wr_hist = {wr_hist[6:0], b};
         press_release(b, 8, 8);
      end
      expect_int("wrap_pulses", pulses - p0, 250);
      expect_int("wrap_count", int'(bit_count), 0);
      expect_int("wrap_history", int'(history), int'(wr_hist));

      // Async reset between edges while HELD
      sw_data = 1'b1;
      btn_n   = 1'b0;
      repeat (8) cyc();
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      expect_int("async_bit_valid", int'(bit_valid), 0);
      expect_int("async_bit_out", int'(bit_out), 0);
      expect_int("async_history", int'(history), 0);
      expect_int("async_count", int'(bit_count), 0);
      @(negedge clk); rst = 1'b1;
      p0 = pulses;
      repeat (6) cyc();
      expect_int("post_reset_no_pulse", pulses - p0, 0);
      cyc();
      expect_int("post_reset_pulse", pulses - p0, 1);
      btn_n = 1'b1;
      repeat (10) cyc();

      // Random segments against the model
      for (int i = 0; i < 80; i++) begin
         btn_n   = 1'($urandom_range(0, 1));
         sw_data = 1'($urandom_range(0, 1));
         ena     = ($urandom_range(0, 7) != 0);
         repeat ($urandom_range(1, 12)) cyc();
      end
      ena = 1'b1;
      btn_n = 1'b1;
      repeat (12) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
